// File: rtl/adder_serial.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock through a single DIGIT-bit adder.
// Latency: done pulses NUM = WIDTH/DIGIT cycles after start is sampled; one result per NUM+1 cycles.
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored while busy.
module adder_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM  = WIDTH / DIGIT;
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);

  // Operand width must split into whole digits.
  generate
    if (WIDTH % DIGIT != 0) begin : g_cfg_err
      $error("adder_serial: WIDTH must be an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [DIGIT-1:0] w_adig;
  logic [DIGIT-1:0] w_bdig;
  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic             w_last;
  logic             w_accept;

  // Operands shift right one digit per RUN cycle, so the active digit is always the low slice.
  assign w_adig   = r_a[DIGIT-1:0];
  assign w_bdig   = r_b[DIGIT-1:0];
  assign w_dsum   = {1'b0, w_adig} + {1'b0, w_bdig} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of the digit; only meaningful for the final (MSB) digit.
  assign w_cmsb   = w_adig[DIGIT-1] ^ w_bdig[DIGIT-1] ^ w_dsum[DIGIT-1];
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: DONE accepts a new start directly for back-to-back operation.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept (subtract folds into inverted b and carry), then one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_dsum[DIGIT];
      // Sum digits enter at the top and walk down, landing in place after NUM cycles.
      r_s     <= (r_s >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: directed corner cases plus random operations on a 16/4 and an 8/8 instance.
// Expected results come from signed/unsigned integer arithmetic, not from a digit-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_adder_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start8;
  logic        sub, cin;
  logic [15:0] a, b;

  logic        busy16, done16, cout16, ovf16;
  logic [15:0] s16;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  s8;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_s;
  logic        exp_c, exp_o;

  adder_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
  );

  adder_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  // Reference: a +/- b +/- cin computed as whole integers, both unsigned (carry/borrow) and signed (overflow).
  function automatic void model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                input logic icin, input logic isub,
                                output logic [15:0] es, output logic ec, output logic eo);
    longint m, ua, ub, sa, sb, r, sr, c;
    m  = longint'(1) << w;
    ua = longint'(ia) & (m - 1);
    ub = longint'(ib) & (m - 1);
    c  = icin ? 1 : 0;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!isub) begin
      r  = ua + ub + c;
      sr = sa + sb + c;
      ec = (r >= m);
    end else begin
      r  = ua - ub - c;
      sr = sa - sb - c;
      ec = (r >= 0);
    end
    es = 16'(r & (m - 1));
    eo = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation at the current falling edge and follow it to its DONE cycle.
  task automatic do_op(input bit wide, input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic isub, input bit repulse);
    int num;
    num = wide ? 4 : 1;
    model(wide ? 16 : 8, ia, ib, icin, isub, exp_s, exp_c, exp_o);
    a = ia; b = ib; cin = icin; sub = isub;
    if (wide) start16 = 1'b1; else start8 = 1'b1;
    for (int i = 0; i < num; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start16 = 1'b0; start8 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      if (repulse && i == 1) begin start16 = 1'b1; a = 16'h1111; end
      if (repulse && i == 2) start16 = 1'b0;
      chk("busy_in_run", wide ? busy16 : busy8, 1);
      chk("done_early",  wide ? done16 : done8, 0);
    end
    @(negedge clk);
    chk("done_pulse", wide ? done16 : done8, 1);
    chk("busy_done",  wide ? busy16 : busy8, 0);
    chk("sum",  wide ? s16 : {8'h00, s8}, exp_s);
    chk("cout", wide ? cout16 : cout8, exp_c);
    chk("ovf",  wide ? ovf16 : ovf8, exp_o);
  endtask

  // One idle cycle after DONE: pulse must end and the result must hold.
  task automatic idle_chk(input bit wide);
    @(negedge clk);
    chk("done_len",  wide ? done16 : done8, 0);
    chk("busy_idle", wide ? busy16 : busy8, 0);
    chk("sum_hold",  wide ? s16 : {8'h00, s8}, exp_s);
    chk("cout_hold", wide ? cout16 : cout8, exp_c);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000; corners[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    bit w;
    rst_n = 1'b1; start16 = 1'b0; start8 = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_s",    s16, 0);
    chk("rst_cout", cout16, 0);
    chk("rst_ovf",  ovf16, 0);
    chk("rst_s8",   s8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    do_op(1, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0); idle_chk(1);
    do_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0); idle_chk(1);
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0); idle_chk(1);
    do_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0); idle_chk(1);
    // Mid-RUN start is ignored; then start held in DONE is accepted back-to-back.
    do_op(1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    do_op(1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0); idle_chk(1);
    do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the second RUN cycle.
    a = 16'h5555; b = 16'h2222; cin = 1'b0; sub = 1'b0; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy16, 0);
    chk("arst_done", done16, 0);
    chk("arst_s",    s16, 0);
    chk("arst_cout", cout16, 0);
    chk("arst_ovf",  ovf16, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_done", done16, 0);
      chk("arst_no_busy", busy16, 0);
    end
    do_op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0); idle_chk(1);

    // Single-digit configuration.
    do_op(0, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0); idle_chk(0);

    // Random operations, mixing back-to-back and idle gaps on both instances.
    for (int i = 0; i < 40; i++) begin
      w = (i < 24) ? 1'b1 : 1'($urandom);
      do_op(w, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_chk(w);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
Name: adder_serial

Overview:
- Parametrised multi-cycle digit-serial adder/subtractor for the ALU; successor to the fixed 4-bit ripple adder.
- Processes one DIGIT-bit slice per clock through a single DIGIT-bit adder, trading latency for area at large WIDTH.
- Adds subtract mode, signed overflow detection and a start/busy/done handshake.
- Used by the multi-cycle ALU path, where the issuing logic waits on done.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per clock; NUM = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result valid.
- s  output  WIDTH  result.
- cout  output  1  carry out of MSB; in subtract mode cout=0 means borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock, asynchronous active-low reset. rst_n low forces state IDLE immediately, with busy=0, done=0, s=0, cout=0, ovf=0 and all internal registers cleared.
- Reset mid-RUN aborts the operation with no done pulse. The first start after rst_n rises is handled normally.
- Arithmetic: add gives {cout,s} = a + b + cin. Subtract gives a + ~b + ~cin, i.e. a - b - cin; cout is the inverted borrow.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 captures a, b (inverted if sub), the initial carry (cin, or ~cin if sub) and sub, clears the digit index to 0, and moves to RUN.
- RUN: at edges E1..E(NUM), digit k = E(k+1) adds bits [k*DIGIT +: DIGIT] with the running carry. The sum slice is written into s and the carry is registered for the next digit.
  - Carry into the MSB is recorded during the final digit.
  - At E(NUM) the state becomes DONE and cout and ovf are written.
- busy=1 exactly while in RUN (NUM cycles). start during RUN is ignored; the operation completes with the original operands.
- DONE: done=1 for exactly one cycle. On the next edge:
  - start=1 is accepted as in IDLE (back-to-back, no idle cycle).
  - otherwise the state returns to IDLE.
- s, cout and ovf are intermediate or undefined while in RUN. They are valid from the DONE cycle and hold until the next accepted start.
- Latency: done is high in the cycle after edge E(NUM), i.e. NUM cycles after start is sampled. Throughput is one result per NUM+1 cycles.
- Operands may change after E0 with no effect on the result.
- NUM=1 (DIGIT=WIDTH) is legal: one RUN cycle, then DONE.
- A non-multiple WIDTH/DIGIT is a configuration error and is flagged at elaboration.

Test Plan:
- WIDTH=16, DIGIT=4, add, a=0x0FFF, b=0x0001, cin=0 -> s=0x1000, cout=0, ovf=0. busy high 4 cycles; done pulses exactly 4 cycles after start is sampled, for 1 cycle only.
- Add a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1, ovf=0. Add a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
- Subtract a=0x0005, b=0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0. Subtract a=0x8000, b=0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1.
- start re-pulsed mid-RUN with a=0x1111 while computing 0x0002+0x0003 -> ignored, result 0x0005. start held during the DONE cycle with 0x0010+0x0020 -> accepted, giving s=0x0030 after 4 more cycles.
- rst_n dropped asynchronously in the 2nd RUN cycle -> busy, done, s, cout and ovf go to 0 before the next edge, with no done pulse. A subsequent start with 0x0001+0x0001 returns s=0x0002.
- WIDTH=8, DIGIT=8, add a=0x80, b=0x80, cin=0 -> s=0x00, cout=1, ovf=1, done 1 cycle after start is sampled.
